// File: rtl/cone_pipe.sv
// Bank of WIDTH C-module logic cells behind a two-stage valid/ready pipeline, with a delivered-result counter.
// Latency: a set accepted at edge N is presented on f/out_valid after edge N+1; one result per cycle at full rate.
// Backpressure: in_ready = !v1 | !v2 | out_ready; a stalled S2 holds f, and S1 holds while full. CONE_PIPE_PARITY_EN adds out_par.
module cone_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   b1,
    input  logic [WIDTH-1:0]   sa,
    input  logic [WIDTH-1:0]   sb,
    input  logic [WIDTH-1:0]   s0,
    input  logic [WIDTH-1:0]   s1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   f,
`ifdef CONE_PIPE_PARITY_EN
    output logic               out_par,
`endif
    output logic [COUNT_W-1:0] out_count
);

    logic             v1_q;
    logic             v2_q;
    logic [WIDTH-1:0] f1_q;
    logic [WIDTH-1:0] f2_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_nxt;
    logic             s1_load;
    logic             s2_load;
    logic             out_hs;

    assign s2_load  = v1_q & (~v2_q | out_ready);
    assign s1_load  = in_valid & (~v1_q | s2_load);
    assign in_ready = ~v1_q | ~v2_q | out_ready;
    assign out_hs   = v2_q & out_ready;

    // Second-level mux per lane: s2 picks the b-side result over the a-side.
    assign f_nxt = (s2_q & f2_q) | (~s2_q & f1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            f1_q <= '0;
            f2_q <= '0;
            s2_q <= '0;
        end else begin
            if (s1_load) begin
                v1_q <= 1'b1;
                f1_q <= (sa & a1) | (~sa & a0);
                f2_q <= (sb & b1) | (~sb & b0);
                s2_q <= s0 | s1;
            end else if (s2_load) begin
                v1_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            f_q  <= '0;
        end else begin
            if (s2_load) begin
                v2_q <= 1'b1;
                f_q  <= f_nxt;
            end else if (out_hs) begin
                v2_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_hs) begin
            out_count <= out_count + 1'b1;
        end
    end

`ifdef CONE_PIPE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (s2_load) begin
            par_q <= ^f_nxt;
        end
    end

    assign out_par = par_q;
`endif

    assign out_valid = v2_q;
    assign f         = f_q;

endmodule

// File: tb/tb_cone_pipe.sv
// Directed bench for cone_pipe: reset, single set, streaming, backpressure, counter wrap, mid-stream reset.
// Expected results come from a reference model pushed into a scoreboard queue on every accepted set.
module tb_cone_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [W-1:0] sa = '0, sb = '0, s0 = '0, s1 = '0;

    logic         in_ready, out_valid;
    logic [W-1:0] f;
    logic [7:0]   out_count;
    logic         in_ready4, out_valid4;
    logic [W-1:0] f4;
    logic [3:0]   out_count4;
`ifdef CONE_PIPE_PARITY_EN
    logic         out_par, out_par4;
`endif

    always #5 clk = ~clk;

    cone_pipe #(.WIDTH(W), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .sa(sa), .sb(sb), .s0(s0), .s1(s1),
        .out_valid(out_valid), .out_ready(out_ready), .f(f),
`ifdef CONE_PIPE_PARITY_EN
        .out_par(out_par),
`endif
        .out_count(out_count)
    );

    cone_pipe #(.WIDTH(W), .COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .sa(sa), .sb(sb), .s0(s0), .s1(s1),
        .out_valid(out_valid4), .out_ready(out_ready), .f(f4),
`ifdef CONE_PIPE_PARITY_EN
        .out_par(out_par4),
`endif
        .out_count(out_count4)
    );

    int           errors = 0;
    int           checks = 0;
    int           hs = 0;
    int           n_acc = 0;
    bit           wrap_seen = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] f_hold;
    int           acc_before;

    function automatic logic [W-1:0] cmod(input logic [W-1:0] xa0, xa1, xb0, xb1,
                                          input logic [W-1:0] xsa, xsb, xs0, xs1);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = (xs0[i] | xs1[i]) ? (xsb[i] ? xb1[i] : xb0[i]) : (xsa[i] ? xa1[i] : xa0[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd();
        a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
        sa = W'($urandom); sb = W'($urandom); s0 = W'($urandom); s1 = W'($urandom);
    endtask

    // One clock: sample handshakes just before the edge, update scoreboard, return at the next negedge.
    task automatic tick();
        logic [W-1:0] e;
        bit           acc;
        bit           ohs;
        #1;
        acc = in_valid && in_ready;
        ohs = out_valid && out_ready;
        if (ohs) begin
            chk("queue_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("f", 32'(f), 32'(e));
`ifdef CONE_PIPE_PARITY_EN
                chk("out_par", 32'(out_par), 32'(^e));
`endif
            end
            hs++;
        end
        if (acc) begin
            sb_q.push_back(cmod(a0, a1, b0, b1, sa, sb, s0, s1));
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        if (hs == 17 && !wrap_seen) begin
            wrap_seen = 1;
            chk("wrap17", 32'(out_count4), 32'd1);
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() > 0; i++) tick();
        chk("drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state, observed while rst_n is still low.
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single set: f1=0xF0, f2=0x33, s2=0xAA -> 0x72.
        a0 = 8'h0F; a1 = 8'hF0; b0 = 8'h33; b1 = 8'hCC;
        sa = 8'hFF; sb = 8'h00; s0 = 8'hAA; s1 = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_early", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("func_f", 32'(f), 32'h72);
        tick();
        chk("one_cycle", 32'(out_valid), 32'd0);

        // 20 back-to-back random sets at full rate.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rnd();
            #1;
            chk("stream_rdy", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain(4);
        chk("stream_cnt", 32'(out_count), 32'd21);
        chk("stream_hs", 32'(hs), 32'd21);

        // Backpressure: out_ready low for 5 cycles with input always offered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc_before = n_acc;
        for (int i = 0; i < 5; i++) begin
            rnd();
            tick();
            if (i == 1) f_hold = f;
            else if (i > 1) chk("hold_f", 32'(f), 32'(f_hold));
        end
        chk("bp_acc", 32'(n_acc - acc_before), 32'd2);
        chk("bp_rdy", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(6);
        chk("bp_cnt", 32'(out_count), 32'd23);
        chk("wrap_cnt", 32'(out_count4), 32'd7);

        // Fill both stages, then reset asynchronously between edges.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd();
        tick();
        tick();
        #1;
        chk("full_rdy", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_f", 32'(f), 32'd0);
        chk("arst_count", 32'(out_count), 32'd0);
        sb_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
